// File: rtl/dcache_axi_wbuf.sv
// Write-back buffer for the data cache: holds one victim line (or an uncached
// store word) and replays it as a single AXI INCR write burst (AW -> W beats -> B).
module dcache_axi_wbuf #(
   parameter int         ADDR_W     = 32,
   parameter int         DATA_W     = 32,
   parameter int         LINE_WORDS = 16,
   parameter logic [3:0] AXI_ID     = 4'd1
) (
   input  logic                         clk,
   input  logic                         rstn,
   input  logic                         wbuf_we,
   input  logic                         wbuf_reset,
   input  logic [LINE_WORDS*DATA_W-1:0] line_in,
   input  logic [ADDR_W-1:0]            addr_in,
   input  logic [3:0]                   wstrb_in,
   input  logic                         w_req,
   input  logic [7:0]                   w_length,
   input  logic [2:0]                   w_size,
   output logic                         w_rdy,
   output logic                         wrt_finish,
   output logic                         bus_err,
   output logic                         awvalid,
   input  logic                         awready,
   output logic [ADDR_W-1:0]            awaddr,
   output logic [7:0]                   awlen,
   output logic [2:0]                   awsize,
   output logic [1:0]                   awburst,
   output logic [3:0]                   awid,
   output logic                         wvalid,
   input  logic                         wready,
   output logic [DATA_W-1:0]            wdata,
   output logic [3:0]                   wstrb,
   output logic                         wlast,
   input  logic                         bvalid,
   output logic                         bready,
   input  logic [1:0]                   bresp
);

   localparam int IDX_W = $clog2(LINE_WORDS);
   localparam int BYT_W = $clog2(DATA_W / 8);
   localparam int OFF_W = $clog2(LINE_WORDS * DATA_W / 8);

   typedef enum logic [3:0] {
      ST_IDLE = 4'b0001,
      ST_AW   = 4'b0010,
      ST_W    = 4'b0100,
      ST_B    = 4'b1000
   } state_e;

   state_e                         state_q, state_d;
   logic [LINE_WORDS*DATA_W-1:0]   line_q, line_d;
   logic [ADDR_W-1:0]              addr_q, addr_d;
   logic [3:0]                     strb_q, strb_d;
   logic [3:0]                     len_q, len_d;
   logic [2:0]                     size_q, size_d;
   logic [3:0]                     cnt_q, cnt_d;
   logic                           fin_q, fin_d;
   logic                           err_q, err_d;
   logic [IDX_W-1:0]               word_idx;
   logic                           unused_bresp;

   assign unused_bresp = bresp[0];

   // Single-beat stores pick their word from the address; bursts walk the line.
   assign word_idx = (len_q != 4'd0) ? IDX_W'(cnt_q) : addr_q[OFF_W-1:BYT_W];

   assign w_rdy      = (state_q == ST_IDLE);
   assign awvalid    = (state_q == ST_AW);
   assign wvalid     = (state_q == ST_W);
   assign bready     = (state_q == ST_B);
   assign awaddr     = (len_q != 4'd0) ? {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}} : addr_q;
   assign awlen      = {4'b0000, len_q};
   assign awsize     = size_q;
   assign awburst    = 2'b01;
   assign awid       = AXI_ID;
   assign wdata      = line_q[DATA_W*word_idx +: DATA_W];
   assign wstrb      = (len_q != 4'd0) ? 4'hF : strb_q;
   assign wlast      = (cnt_q == len_q);
   assign wrt_finish = fin_q;
   assign bus_err    = err_q;

   always_comb begin
      state_d = state_q;
      line_d  = line_q;
      addr_d  = addr_q;
      strb_d  = strb_q;
      len_d   = len_q;
      size_d  = size_q;
      cnt_d   = cnt_q;
      fin_d   = fin_q;
      err_d   = err_q;
      // Clear first so a coincident B completion below takes priority.
      if (wbuf_reset) begin
         fin_d = 1'b0;
         err_d = 1'b0;
      end
      unique case (state_q)
         ST_IDLE: begin
            if (wbuf_we) begin
               line_d = line_in;
               addr_d = addr_in;
               strb_d = wstrb_in;
            end
            if (w_req) begin
               len_d   = (w_length > 8'd15) ? 4'd15 : w_length[3:0];
               size_d  = w_size;
               fin_d   = 1'b0;
               err_d   = 1'b0;
               cnt_d   = '0;
               state_d = ST_AW;
            end
         end
         ST_AW: begin
            if (awready) state_d = ST_W;
         end
         ST_W: begin
            if (wready) begin
               cnt_d = cnt_q + 4'd1;
               if (wlast) state_d = ST_B;
            end
         end
         ST_B: begin
            if (bvalid) begin
               fin_d   = 1'b1;
               err_d   = bresp[1];
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      line_q <= line_d;
      addr_q <= addr_d;
      strb_q <= strb_d;
      len_q  <= len_d;
      size_q <= size_d;
      if (!rstn) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         fin_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         fin_q   <= fin_d;
         err_q   <= err_d;
      end
   end

endmodule

// File: doc/dcache_axi_wbuf.md
Name: dcache_axi_wbuf

Overview:
Write-back buffer and AXI write-channel engine sitting directly downstream of the data-cache main FSM.
- Captures a victim cache line (or uncached store word) when the FSM pulses its buffer write-enable.
- On the FSM's write request, issues one AXI write burst (AW, then W beats, then B).
- Reports ready and finish status back to the FSM.
- Drives the write half of the core's AXI master bridge.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, AXI data width (one beat = one word)
LINE_WORDS, 16, words per cache line (line buffer = LINE_WORDS*DATA_W bits)
AXI_ID, 4'd1, constant AWID for data-cache writes

Ports:
clk  in  1  clock
rstn  in  1  synchronous active-low reset
wbuf_we  in  1  capture line_in/addr_in/wstrb_in this cycle (honoured only in IDLE)
wbuf_reset  in  1  clear wrt_finish and bus_err
line_in  in  LINE_WORDS*DATA_W  victim line, word i at bits [DATA_W*i +: DATA_W]
addr_in  in  ADDR_W  victim line address or uncached store address
wstrb_in  in  4  byte strobe for uncached single-beat store
w_req  in  1  FSM write request (level)
w_length  in  8  AXI len (0 = single beat, 15 = full line)
w_size  in  3  AXI size
w_rdy  out  1  engine accepts w_req this cycle
wrt_finish  out  1  sticky: last B response received
bus_err  out  1  sticky: BRESP[1] was set on completion
awvalid  out  1  AXI AW valid
awready  in  1  AXI AW ready
awaddr  out  ADDR_W  AXI AW address
awlen  out  8  AXI AW length
awsize  out  3  AXI AW size
awburst  out  2  constant 2'b01 (INCR)
awid  out  4  constant AXI_ID
wvalid  out  1  AXI W valid
wready  in  1  AXI W ready
wdata  out  DATA_W  AXI W data
wstrb  out  4  AXI W strobe
wlast  out  1  AXI W last
bvalid  in  1  AXI B valid
bready  out  1  AXI B ready
bresp  in  2  AXI B response

Behaviour:
Reset (rstn=0 at clk edge):
- State goes to IDLE.
- awvalid, wvalid, bready, wrt_finish, bus_err = 0; beat counter = 0.
- Buffer contents don't care. Applies mid-burst too: the transaction is abandoned.

States: IDLE, AW, W, B (one-hot).

IDLE:
- w_rdy=1; all AXI valids 0.
- wbuf_we=1 registers line_in, addr_in, wstrb_in.
- w_req=1 accepts the request:
  - latch len = min(w_length,15) and size = w_size;
  - clear wrt_finish and bus_err; beat counter = 0; go to AW.
- If wbuf_we and w_req arrive in the same cycle, the burst uses the newly captured data.

AW:
- awvalid=1, held stable until awready. On handshake go to W.
- awaddr: line-aligned {addr[ADDR_W-1:6],6'b0} when len!=0; addr as latched when len==0.
- awlen=len, awsize=size. These outputs are valid only while awvalid=1.

W:
- wvalid=1.
- wdata = word[cnt] when len!=0; word[addr[5:2]] when len==0.
- wstrb = 4'hF when len!=0; latched wstrb_in when len==0.
- wlast = (cnt==len[3:0]).
- On wvalid&&wready: cnt increments; if wlast, go to B.
- wdata/wstrb/wlast hold while wready=0.

B:
- bready=1.
- On bvalid: wrt_finish<=1, bus_err<=bresp[1], go to IDLE.

Other rules:
- W is issued only after the AW handshake; no overlap.
- Exactly len+1 beats per burst.
- w_rdy is 0 in AW, W and B. wbuf_we and w_req are ignored outside IDLE (buffer is protected during a burst).
- wbuf_reset clears wrt_finish/bus_err in any state. If it coincides with the B handshake, set wins.
- wrt_finish is a registered output: it goes high the cycle after the B handshake and stays high until wbuf_reset or the next accept.
- Latency with an always-ready slave: accept at cycle 0, AW at cycle 1, W beats at cycles 2..len+2, B at cycle len+3, wrt_finish visible at cycle len+4.

Test Plan:
- Full-line write-back: wbuf_we with word i = 0x1000+i and addr 0x8000_1234, then w_req len=15 size=2 -> one AW with addr 0x8000_1200, len 15, burst INCR; 16 W beats carrying 0x1000..0x100F, strb F, wlast only on the 16th; wrt_finish=1 after B.
- Uncached store: addr 0xBFD0_0008, wstrb_in 0011, len=0, size=1 -> awaddr 0xBFD0_0008, awlen 0, one beat = word[2] with strb 0011 and wlast=1.
- Backpressure: awready delayed 3 cycles and wready toggling 1010... -> AW/W payloads stay stable while not ready; no beat is lost or duplicated; beat count = 16.
- Protection: in state W, pulse wbuf_we with different data and hold w_req -> transmitted data unchanged, w_rdy=0, no second AW until back in IDLE.
- Status rules: bresp=2'b10 -> bus_err=1 with wrt_finish=1. Then wbuf_reset -> both 0. wbuf_reset coincident with bvalid -> wrt_finish=1.
- Reset mid-burst: rstn=0 after 5 beats -> the next cycle has all valids 0, state IDLE, w_rdy=1; a new request then runs a full 16-beat burst.
